// File: rtl/key_press_conditioner_pkg.sv
// rtl/key_press_conditioner_pkg.sv - state encoding, default timing and counter sizing for the key conditioner
package key_press_conditioner_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } kpc_state_e;

   localparam int DEF_NUM_KEYS        = 4;
   localparam int DEF_DEBOUNCE_CYCLES = 500000;
   localparam int DEF_REPEAT_DELAY    = 25000000;
   localparam int DEF_REPEAT_PERIOD   = 10000000;

   // Repeat timings only widen the counters when auto-repeat is built in.
   function automatic int cnt_width(input int deb, input int dly, input int per, input bit rpt_en);
      int m;
      m = deb;
      if (rpt_en && dly > m) m = dly;
      if (rpt_en && per > m) m = per;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/key_synchroniser.sv
// rtl/key_synchroniser.sv - per-bit two-flop synchroniser for raw pushbuttons, resets to released (high)
module key_synchroniser #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta <= '1;
         dout <= '1;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/key_press_conditioner.sv
// rtl/key_press_conditioner.sv - debounced one-cycle key press pulses with held flag; KEY_AUTOREPEAT_EN adds auto-repeat
module key_press_conditioner
   import key_press_conditioner_pkg::*;
#(
   parameter int NUM_KEYS        = DEF_NUM_KEYS,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key_raw_n,
   output logic [NUM_KEYS-1:0] key,
   output logic                key_held
);

`ifdef KEY_AUTOREPEAT_EN
   localparam bit RPT_EN = 1'b1;
`else
   localparam bit RPT_EN = 1'b0;
`endif
   localparam int            CW      = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD, RPT_EN);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [NUM_KEYS-1:0] raw_sync;
   logic [NUM_KEYS-1:0] s;
   logic [NUM_KEYS-1:0] cand;
   logic [CW-1:0]       cnt;
   kpc_state_e          state;
   logic                rpt_due;

   key_synchroniser #(.WIDTH(NUM_KEYS)) u_sync (
      .clock (clock),
      .reset (reset),
      .din   (key_raw_n),
      .dout  (raw_sync)
   );

   assign s = ~raw_sync;

`ifdef KEY_AUTOREPEAT_EN
   localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

   logic [CW-1:0] rpt;
   logic          rpt_later;

   assign rpt_due = (rpt == (rpt_later ? PER_LAST : DLY_LAST));

   // Timer is held at zero until the first pulse, then saturates at the due point while released.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rpt       <= '0;
         rpt_later <= 1'b0;
      end else if (state == IDLE || state == PRESS_WAIT) begin
         rpt       <= '0;
         rpt_later <= 1'b0;
      end else if (state == HELD && s != '0 && rpt_due) begin
         rpt       <= '0;
         rpt_later <= 1'b1;
      end else if (!rpt_due) begin
         rpt <= rpt + 1'b1;
      end
   end
`else
   assign rpt_due = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         key      <= '0;
         key_held <= 1'b0;
         cnt      <= '0;
         cand     <= '0;
      end else begin
         key <= '0;
         case (state)
            IDLE: begin
               if (s != '0) begin
                  cand  <= s;
                  cnt   <= '0;
                  state <= PRESS_WAIT;
               end
            end
            PRESS_WAIT: begin
               if (s == '0) begin
                  state <= IDLE;
               end else if (s != cand) begin
                  cand <= s;
                  cnt  <= '0;
               end else if (cnt == DB_LAST) begin
                  key      <= cand;
                  key_held <= 1'b1;
                  state    <= HELD;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HELD: begin
               if (s == '0) begin
                  cnt   <= '0;
                  state <= RELEASE_WAIT;
               end else if (rpt_due) begin
                  key <= cand;
               end
            end
            RELEASE_WAIT: begin
               if (s != '0) begin
                  state <= HELD;
               end else if (cnt == DB_LAST) begin
                  key_held <= 1'b0;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_key_press_conditioner.sv
// tb/tb_key_press_conditioner.sv - directed bench for key_press_conditioner (DEBOUNCE 4, REPEAT 10/5)
module tb_key_press_conditioner;

`ifdef KEY_AUTOREPEAT_EN
   localparam int RPT = 1;
`else
   localparam int RPT = 0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] key_raw_n = 4'hF;
   logic [3:0] key;
   logic       key_held;

   key_press_conditioner #(
      .NUM_KEYS        (4),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (5)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .key_raw_n (key_raw_n),
      .key       (key),
      .key_held  (key_held)
   );

   always #5 clock = ~clock;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc;
   int   p_time[$];
   int   p_val[$];
   int   held_rise;
   int   held_fall;
   int   fall_cnt;
   logic prev_held;

   task automatic chk(input string tag, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic start();
      cyc       = -1;
      p_time.delete();
      p_val.delete();
      held_rise = -1;
      held_fall = -1;
      fall_cnt  = 0;
      prev_held = key_held;
   endtask

   // Edge index 0 is the first edge that samples the first raw value of a scenario.
   task automatic seg(input logic [3:0] raw, input int n);
      for (int i = 0; i < n; i++) begin
         key_raw_n = raw;
         @(posedge clock);
         #1;
         cyc++;
         if (key != 4'h0) begin
            p_time.push_back(cyc);
            p_val.push_back(int'(key));
         end
         if (key_held && !prev_held) held_rise = cyc;
         if (!key_held && prev_held) begin
            held_fall = cyc;
            fall_cnt++;
         end
         prev_held = key_held;
      end
   endtask

   task automatic chk_pulses(input string tag, input int val, input int n, input int first);
      chk({tag, " count"}, p_time.size(), n);
      for (int i = 0; i < n && i < p_time.size(); i++) begin
         chk({tag, " time"}, p_time[i], (i == 0) ? first : first + 10 + 5 * (i - 1));
         chk({tag, " value"}, p_val[i], val);
      end
   endtask

   initial begin
      #2 reset = 1'b0;
      key_raw_n = 4'b1110;
      repeat (3) @(posedge clock);
      #1;
      chk("reset key", int'(key), 0);
      chk("reset held", int'(key_held), 0);
      key_raw_n = 4'hF;
      reset = 1'b1;
      start();
      seg(4'hF, 6);
      chk_pulses("idle", 0, 0, 0);

      start();
      seg(4'b1110, 20);
      seg(4'hF, 12);
      chk_pulses("press", 1, (RPT != 0) ? 3 : 1, 6);
      chk("press held_rise", held_rise, 6);
      chk("press held_fall", held_fall, 26);

      start();
      seg(4'b1110, 2);
      seg(4'hF, 2);
      seg(4'b1110, 2);
      seg(4'hF, 2);
      seg(4'b1110, 8);
      seg(4'hF, 10);
      chk_pulses("bounce", 1, 1, 14);
      chk("bounce held_fall", held_fall, 22);

      start();
      seg(4'b1110, 3);
      seg(4'hF, 8);
      chk_pulses("glitch", 0, 0, 0);
      chk("glitch held_rise", held_rise, -1);

      start();
      seg(4'b1110, 2);
      seg(4'b1100, 8);
      seg(4'hF, 10);
      chk_pulses("change", 3, 1, 8);
      chk("change held_fall", held_fall, 16);

      start();
      seg(4'b1110, 7);
      seg(4'b1100, 2);
      seg(4'hF, 2);
      seg(4'b1110, 1);
      seg(4'hF, 12);
      chk_pulses("extra", 1, 1, 6);
      chk("extra held_rise", held_rise, 6);
      chk("extra held_fall", held_fall, 18);
      chk("extra fall_cnt", fall_cnt, 1);

      start();
      seg(4'b1110, 4);
      reset = 1'b0;
      key_raw_n = 4'hF;
      @(posedge clock);
      #1;
      reset = 1'b1;
      seg(4'hF, 10);
      chk_pulses("cancel", 0, 0, 0);
      chk("cancel held_rise", held_rise, -1);

      start();
      seg(4'b1110, 12);
      chk_pulses("prereset", 1, 1, 6);
      reset = 1'b0;
      #1;
      chk("midreset key", int'(key), 0);
      chk("midreset held", int'(key_held), 0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      start();
      seg(4'b1110, 12);
      chk_pulses("postreset", 1, 1, 6);
      seg(4'hF, 12);

      start();
      seg(4'b1110, 40);
      seg(4'hF, 12);
      chk_pulses("hold40", 1, (RPT != 0) ? 7 : 1, 6);
      chk("hold40 held_fall", held_fall, 46);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/key_press_conditioner.md
KEY_PRESS_CONDITIONER -- requirements
Module: key_press_conditioner

Interface
REQ-001 Parameter NUM_KEYS, default 4, number of pushbuttons and width of the key pattern.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, number of stable clock cycles needed to accept a press or a release (10 ms at 50 MHz).
REQ-003 Parameter REPEAT_DELAY, default 25000000, cycles from the first pulse to the first auto-repeat pulse.
REQ-004 Parameter REPEAT_PERIOD, default 10000000, cycles between later auto-repeat pulses.
REQ-005 clock  input  1  the single system clock; all state SHALL be updated on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 key_raw_n  input  NUM_KEYS  raw, asynchronous DE1-SoC pushbuttons; active-low (0 = pressed).
REQ-008 key  output  NUM_KEYS  registered one-cycle press pulse carrying the accepted key pattern (active-high); all zeros otherwise.
REQ-009 key_held  output  1  registered; high while an accepted press has not yet been accepted as released.

Function
REQ-010 key_raw_n SHALL pass through a 2-flop synchroniser and be inverted to form sample s; s SHALL be the only value that reaches the state machine.
REQ-011 States: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT; a debounce counter cnt; a captured pattern cand.
REQ-012 IDLE, s!=0: cand<=s, cnt<=0, go to PRESS_WAIT; otherwise stay in IDLE.
REQ-013 PRESS_WAIT:
- s==0: return to IDLE with no pulse.
- s nonzero and s!=cand: cand<=s, cnt<=0, stay.
- s==cand and cnt==DEBOUNCE_CYCLES-1: key<=cand for one cycle, go to HELD.
- otherwise: cnt increments.
REQ-014 Latency: if raw is stable from the first edge N that samples it, key SHALL be valid in the cycle after edge N+DEBOUNCE_CYCLES+2.
REQ-015 HELD: key_held=1. Extra keys or pattern changes SHALL NOT produce pulses. s==0: cnt<=0, go to RELEASE_WAIT.
REQ-016 RELEASE_WAIT: key_held stays 1.
- s!=0: return to HELD; no pulse, and the repeat timer is not restarted.
- s==0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE and clear key_held in the same edge.
- otherwise: cnt increments.
REQ-017 key SHALL be high for at most one cycle per event and SHALL be zero in every cycle that has no event.
REQ-018 cnt SHALL be sized $clog2 of the largest timing parameter in use and SHALL NOT wrap.

Reset
REQ-019 When reset is low: state=IDLE, key=0, key_held=0, cnt=0, cand=0, repeat timer=0, synchroniser flops=released.
REQ-020 Reset asserted mid-press SHALL cancel any pending pulse.
REQ-021 A button still held when reset releases SHALL be treated as a new press and pulse after full debounce (REQ-014).

Configuration
REQ-022 Macro KEY_AUTOREPEAT_EN.
REQ-023 Defined: in HELD, key<=cand again REPEAT_DELAY cycles after the first pulse, then every REPEAT_PERIOD cycles; the timer clears on entering IDLE.
REQ-024 Undefined: exactly one pulse per accepted press, REPEAT_DELAY and REPEAT_PERIOD are unused, and no repeat-timer logic is synthesised.

Structure
REQ-025 Package key_press_conditioner_pkg SHALL hold the state encoding and the default timing constants.
REQ-026 Sub-module key_synchroniser SHALL contain the parameterised 2-flop synchroniser per bit, reset to released.
REQ-027 Outputs SHALL be driven only from flops; no combinational path from key_raw_n to key.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-028 key_raw_n=4'b1110 held low 20 cycles from edge N -> key=4'b0001 only after edge N+6; key_held rises at N+6 and falls 6 edges after release is sampled.
REQ-029 Bit0 bounces every 2 cycles for 10 cycles, then is held -> exactly one pulse, 4'b0001; a 3-cycle glitch -> no pulse, key_held stays 0.
REQ-030 1110 for 2 cycles then 1100 held -> a single pulse of 4'b0011, 6 edges after the change is sampled.
REQ-031 Second key pressed while in HELD -> no pulse; a 2-cycle release bounce -> no pulse and key_held stays 1.
REQ-032 Reset pulsed low mid-hold -> key=0 and key_held=0 immediately; button still held -> new 4'b0001 pulse 6 edges after reset deasserts.
REQ-033 Hold 40 cycles with KEY_AUTOREPEAT_EN -> pulses after edges N+6, N+16, N+21, N+26, ...; same hold without the macro -> only the N+6 pulse.
